div_step_ctrl: RTL
==================

// Module: div_step_ctrl
// PURPOSE
//  Sequencer for the online-division recurrence, downstream of quotient-digit selection.
//  - Paces the residual/selection stages with enable/rd_addr.
//  - Accepts the dividend digit stream (x_value), zero-pads it past NUM_DIGITS.
//  - Captures each selected q_value into the on-the-fly q_plus_vec/q_minus_vec fed back to the residual adder.
//  - Emits quotient digits downstream through a valid/ready register.
// PARAMETERS
//  unrolling     64  width of q_plus_vec/q_minus_vec
//  online_delay  3   initial steps whose q_value is discarded
//  ADDR_WIDTH    7   width of rd_addr; must satisfy 2**ADDR_WIDTH >= NUM_DIGITS+online_delay
//  NUM_DIGITS    64  quotient digits per operation; must be <= unrolling
// PORTS
//  clk           in   1           rising-edge clock
//  asyn_reset    in   1           asynchronous reset, active-low
//  start         in   1           begin operation; sampled in IDLE only
//  x_valid       in   1           upstream digit valid
//  x_value       in   2           upstream digit {plus,minus}
//  x_ready       out  1           upstream digit accepted this cycle
//  q_value       in   2           selected digit from selection stage (combinational, same cycle)
//  enable        out  1           step strobe to residual/selection registers
//  rd_addr       out  ADDR_WIDTH  step index of current step; 0 on first step
//  x_step        out  2           digit used by this step (accepted x_value or 2'b00 pad)
//  q_plus_vec    out  unrolling   plus bits of captured quotient digits
//  q_minus_vec   out  unrolling   minus bits of captured quotient digits
//  q_out         out  2           quotient digit to downstream
//  q_out_valid   out  1           q_out holds an unaccepted digit
//  q_out_ready   in   1           downstream accepts q_out
//  busy          out  1           state != IDLE
//  done          out  1           one-cycle pulse: last digit accepted
//  err           out  1           sticky: q_value==2'b11 captured
// BEHAVIOUR
//  - Digit code {plus,minus}: 10=+1, 01=-1, 00=0; 11 illegal.
//  - Reset (async, any state): state=IDLE, step count=0.
//    All outputs 0: enable, rd_addr, x_ready, x_step, vectors, q_out, q_out_valid, busy, done, err.
//  - States:
//    - IDLE: start -> PRIME; clears vectors, err, step count.
//    - PRIME: steps 0..online_delay-1.
//    - ITER: steps online_delay..T-1, where T = NUM_DIGITS+online_delay.
//    - DRAIN: waits for the last q_out to be accepted.
//  - slot_free = !q_out_valid | q_out_ready.
//    - In PRIME, slot_free is treated as 1.
//  - need_x = step < NUM_DIGITS.
//  - fire = (PRIME|ITER) & slot_free & (x_valid | !need_x).
//    - enable = fire; x_ready = fire & need_x.
//    - x_step = need_x ? x_value : 00.
//    - rd_addr = step; step increments on fire.
//  - PRIME fire: q_value ignored.
//    - After step online_delay-1 -> ITER.
//  - ITER fire at step s, with j = s-online_delay:
//    - q_plus_vec[unrolling-1-j]  <= q_value[1]
//    - q_minus_vec[unrolling-1-j] <= q_value[0]
//    - q_out <= q_value; q_out_valid <= 1.
//  - q_value 11: stored as 00 in vectors and q_out; err <= 1.
//  - Step T-1 -> DRAIN.
//  - DRAIN: q_out_valid & q_out_ready -> done=1, q_out_valid<=0, -> IDLE.
//  - Simultaneous accept + fire: new digit overwrites; q_out_valid stays 1.
//  - Stalls:
//    - x_valid low while need_x: no fire, all registers hold.
//    - Downstream stall: no fire in ITER; rd_addr and vectors hold.
//  - start while busy: ignored. Vector bits beyond NUM_DIGITS stay 0.
//  - Latency: start -> first enable next cycle, if x_valid.
//    - First q_out_valid one cycle after the online_delay+1-th fire.
//  - No combinational path q_out_ready -> q_out.
//    - Combinational paths exist q_out_ready/x_valid -> enable/x_ready.
// STRUCTURE
//  - Shared header div_defs.vh:
//    - Digit codes DIG_POS=2'b10, DIG_NEG=2'b01, DIG_ZERO=2'b00.
//    - State encodings IDLE/PRIME/ITER/DRAIN.
//  - One sub-module, div_digit_out_reg: q_out/q_out_valid holding register with load/accept.
//  - FSM, step counter and vector writes are inline.
// TESTING (unrolling=8, online_delay=3, NUM_DIGITS=4)
//  1. Continuous flow: start, x_valid=1, q_ready=1; q_value=10,01,00,10 on steps 3..6.
//     -> 7 enables, rd_addr 0..6.
//     -> q_plus_vec=8'b1001_0000, q_minus_vec=8'b0100_0000.
//     -> q_out 10,01,00,10; done on last accept.
//  2. Input bubbles: x_valid low on steps 1 and 3 for 2 cycles each.
//     -> no enable those cycles, rd_addr held.
//     -> x_ready only on steps 0..3; x_step=00 on steps 4..6 regardless of x_value.
//  3. Backpressure: q_out_ready=0 from first q_out for 3 cycles.
//     -> enable low, q_out stable.
//     -> resumes on release; no digit lost or duplicated.
//  4. Illegal digit: q_value=11 at step 4.
//     -> vectors bit 6 = 0/0, q_out=00, err=1 until next start.
//  5. Reset mid-ITER: assert asyn_reset at step 5 between clock edges.
//     -> immediate IDLE, all outputs 0.
//     -> new start runs a clean operation with rd_addr from 0.
//  6. start pulsed during busy: ignored; rd_addr sequence identical to test 1.

Source files
------------

// File: rtl/div_step_ctrl_pkg.sv
// div_step_ctrl_pkg: digit codes, sequencer states and digit sanitising shared by the division controller
package div_step_ctrl_pkg;
  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;
  localparam logic [1:0] DIG_ZERO = 2'b00;
  typedef enum logic [1:0] {IDLE, PRIME, ITER, DRAIN} state_e;
  function automatic logic [1:0] sanitize(input logic [1:0] d);
    return (d == (DIG_POS | DIG_NEG)) ? DIG_ZERO : d;
  endfunction
endpackage

// File: rtl/div_step_ctrl_digit_out_reg.sv
// div_digit_out_reg: quotient digit holding register; a load wins over a same-cycle accept
module div_digit_out_reg
  import div_step_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [1:0] d_i,
  input  logic       accept_i,
  output logic [1:0] q_o,
  output logic       valid_o
);
  logic [1:0] q_q, q_d;
  logic       valid_q, valid_d;
  always_comb begin
    q_d     = load_i ? d_i : q_q;
    valid_d = load_i | (valid_q & ~accept_i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= DIG_ZERO;
      valid_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end
  assign q_o     = q_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/div_step_ctrl.sv
// div_step_ctrl: online-division step sequencer; paces residual/selection stages,
// builds the on-the-fly quotient vectors and hands digits downstream via valid/ready.
module div_step_ctrl
  import div_step_ctrl_pkg::*;
#(
  parameter int unrolling    = 64,
  parameter int online_delay = 3,
  parameter int ADDR_WIDTH   = 7,
  parameter int NUM_DIGITS   = 64
)(
  input  logic                  clk,
  input  logic                  asyn_reset,
  input  logic                  start,
  input  logic                  x_valid,
  input  logic [1:0]            x_value,
  output logic                  x_ready,
  input  logic [1:0]            q_value,
  output logic                  enable,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [1:0]            x_step,
  output logic [unrolling-1:0]  q_plus_vec,
  output logic [unrolling-1:0]  q_minus_vec,
  output logic [1:0]            q_out,
  output logic                  q_out_valid,
  input  logic                  q_out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int T  = NUM_DIGITS + online_delay;
  localparam int IW = (unrolling > 1) ? $clog2(unrolling) : 1;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] step_q, step_d, j;
  logic [unrolling-1:0]  qp_q, qp_d, qm_q, qm_d;
  logic                  err_q, err_d;
  logic                  active, slot_free, need_x, fire, load, accept;
  logic [1:0]            q_clean;
  logic [IW-1:0]         idx;
  assign active    = (state_q == PRIME) | (state_q == ITER);
  // During priming no digit is emitted, so downstream backpressure must not stall it
  assign slot_free = (state_q == PRIME) | ~q_out_valid | q_out_ready;
  assign need_x    = step_q < ADDR_WIDTH'(NUM_DIGITS);
  assign fire      = active & slot_free & (x_valid | ~need_x);
  assign load      = fire & (state_q == ITER);
  assign accept    = q_out_valid & q_out_ready;
  assign q_clean   = sanitize(q_value);
  assign j         = step_q - ADDR_WIDTH'(online_delay);
  assign idx       = IW'(unrolling - 1) - IW'(j);
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    qp_d    = qp_q;
    qm_d    = qm_q;
    err_d   = err_q;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = PRIME;
        step_d  = '0;
        qp_d    = '0;
        qm_d    = '0;
        err_d   = 1'b0;
      end
      PRIME: if (fire) begin
        step_d  = step_q + 1'b1;
        state_d = (step_q == ADDR_WIDTH'(online_delay - 1)) ? ITER : PRIME;
      end
      ITER: if (fire) begin
        step_d    = step_q + 1'b1;
        qp_d[idx] = q_clean[1];
        qm_d[idx] = q_clean[0];
        err_d     = err_q | (q_value != q_clean);
        state_d   = (step_q == ADDR_WIDTH'(T - 1)) ? DRAIN : ITER;
      end
      DRAIN: if (accept) begin
        done    = 1'b1;
        state_d = IDLE;
        step_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      qp_q    <= '0;
      qm_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      qp_q    <= qp_d;
      qm_q    <= qm_d;
      err_q   <= err_d;
    end
  end
  div_digit_out_reg u_out (
    .clk     (clk),
    .rst_n   (asyn_reset),
    .load_i  (load),
    .d_i     (q_clean),
    .accept_i(accept),
    .q_o     (q_out),
    .valid_o (q_out_valid)
  );
  assign enable      = fire;
  assign x_ready     = fire & need_x;
  assign x_step      = (active & need_x) ? x_value : DIG_ZERO;
  assign rd_addr     = step_q;
  assign q_plus_vec  = qp_q;
  assign q_minus_vec = qm_q;
  assign busy        = state_q != IDLE;
  assign err         = err_q;
endmodule
